// File: rtl/bcd2counter.sv
// bcd2counter: converts a BCD UTC calendar date/time into unix seconds.
// Iterative: one cycle per elapsed year since the epoch and one per elapsed
// month of the target year, followed by a single constant-multiply sum.
module bcd2counter #(
  parameter int EPOCH_YEAR = 1970,
  parameter int MAX_YEAR   = 9999,
  parameter int COUNTER_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          year_bcd,
  input  logic [7:0]           month_bcd,
  input  logic [7:0]           day_bcd,
  input  logic [7:0]           hour_bcd,
  input  logic [7:0]           minute_bcd,
  input  logic [7:0]           second_bcd,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [COUNTER_W-1:0] counter
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    YEARS  = 3'd2,
    MONTHS = 3'd3,
    SUM    = 3'd4
  } state_t;

  localparam logic [13:0] EPOCH_Y    = 14'(EPOCH_YEAR);
  localparam logic [13:0] MAX_Y      = 14'(MAX_YEAR);
  // Residues of the epoch year; the wrap counters start here and step with y.
  localparam logic [1:0]  R4_EPOCH   = 2'(EPOCH_YEAR % 4);
  localparam logic [6:0]  R100_EPOCH = 7'(EPOCH_YEAR % 100);
  localparam logic [8:0]  R400_EPOCH = 9'(EPOCH_YEAR % 400);

  function automatic logic [4:0] days_in_month(input logic [3:0] mon, input logic leap);
    logic [4:0] d;
    case (mon)
      4'd2:                      d = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   d = 5'd30;
      default:                   d = 5'd31;
    endcase
    return d;
  endfunction

  // Out-of-range nibbles may wrap here; such inputs are rejected separately.
  function automatic logic [13:0] bcd4_to_bin(input logic [15:0] b);
    return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100 +
           14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
  endfunction

  function automatic logic [6:0] bcd2_to_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic nibbles_ok(input logic [55:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Leap test straight from BCD digits: year%4 equals (tens/ones)%4 because
  // 100 is a multiple of 4; on a century the century number decides.
  function automatic logic leap_from_bcd(input logic [15:0] b);
    logic [6:0] lo;
    logic [6:0] cen;
    lo  = bcd2_to_bin(b[7:0]);
    cen = bcd2_to_bin(b[15:8]);
    if (lo != 7'd0) return (lo[1:0] == 2'b00);
    return (cen[1:0] == 2'b00);
  endfunction

  state_t state, state_n;
  logic   done_n, err_n;

  // Request latched on the start edge
  logic [15:0] year_l;
  logic [7:0]  month_l, day_l, hour_l, min_l, sec_l;

  // Binary fields captured in CHECK
  logic [13:0] year_b;
  logic [3:0]  month_b;
  logic [4:0]  day_b, hour_b;
  logic [5:0]  min_b, sec_b;
  logic        leap_t;

  // Iteration state
  logic [13:0] y;
  logic [1:0]  r4;
  logic [6:0]  r100;
  logic [8:0]  r400;
  logic [3:0]  m;
  logic [21:0] days;

  // Decode of the latched request, used during CHECK
  logic [13:0] yb_c;
  logic [6:0]  mb_c, db_c, hb_c, nb_c, sb_c;
  logic        leap_c, nib_ok_c, in_range_c, valid_c;
  logic        leap_y;
  logic [21:0] year_days;
  logic [37:0] total_c;

  assign yb_c     = bcd4_to_bin(year_l);
  assign mb_c     = bcd2_to_bin(month_l);
  assign db_c     = bcd2_to_bin(day_l);
  assign hb_c     = bcd2_to_bin(hour_l);
  assign nb_c     = bcd2_to_bin(min_l);
  assign sb_c     = bcd2_to_bin(sec_l);
  assign leap_c   = leap_from_bcd(year_l);
  assign nib_ok_c = nibbles_ok({year_l, month_l, day_l, hour_l, min_l, sec_l});

  assign in_range_c = (yb_c >= EPOCH_Y) && (yb_c <= MAX_Y) &&
                      (mb_c != 7'd0) && (mb_c <= 7'd12) &&
                      (db_c != 7'd0) &&
                      (db_c <= {2'b00, days_in_month(mb_c[3:0], leap_c)}) &&
                      (hb_c <= 7'd23) && (nb_c <= 7'd59) && (sb_c <= 7'd59);
  assign valid_c    = nib_ok_c && in_range_c;

  assign leap_y    = (r4 == 2'd0) && ((r100 != 7'd0) || (r400 == 9'd0));
  assign year_days = leap_y ? 22'd366 : 22'd365;

  // day_b is at least 1 here, so the subtraction never wraps.
  assign total_c = 38'(days + 22'(day_b) - 22'd1) * 38'd86400 +
                   38'(hour_b) * 38'd3600 + 38'(min_b) * 38'd60 + 38'(sec_b);

  assign busy = (state != IDLE);

  // Next-state and done/err decode; CHECK skips phases with zero iterations
  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = CHECK;
      end
      CHECK: begin
        if (!valid_c) begin
          state_n = IDLE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else if (yb_c != EPOCH_Y) begin
          state_n = YEARS;
        end else if (mb_c != 7'd1) begin
          state_n = MONTHS;
        end else begin
          state_n = SUM;
        end
      end
      YEARS: begin
        if (y + 14'd1 == year_b) state_n = (month_b != 4'd1) ? MONTHS : SUM;
      end
      MONTHS: begin
        if (m + 4'd1 == month_b) state_n = SUM;
      end
      SUM: begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers: state, handshake outputs and the published counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      counter <= '0;
    end else begin
      state <= state_n;
      done  <= done_n;
      err   <= err_n;
      if (state == SUM) counter <= COUNTER_W'(total_c);
    end
  end

  // Datapath registers: request latch, decoded fields and day accumulation
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (start) begin
          year_l  <= year_bcd;
          month_l <= month_bcd;
          day_l   <= day_bcd;
          hour_l  <= hour_bcd;
          min_l   <= minute_bcd;
          sec_l   <= second_bcd;
        end
      end
      CHECK: begin
        year_b  <= yb_c;
        month_b <= mb_c[3:0];
        day_b   <= db_c[4:0];
        hour_b  <= hb_c[4:0];
        min_b   <= nb_c[5:0];
        sec_b   <= sb_c[5:0];
        leap_t  <= leap_c;
        y       <= EPOCH_Y;
        r4      <= R4_EPOCH;
        r100    <= R100_EPOCH;
        r400    <= R400_EPOCH;
        m       <= 4'd1;
        days    <= '0;
      end
      YEARS: begin
        days <= days + year_days;
        y    <= y + 14'd1;
        r4   <= r4 + 2'd1;
        r100 <= (r100 == 7'd99)  ? 7'd0 : r100 + 7'd1;
        r400 <= (r400 == 9'd399) ? 9'd0 : r400 + 9'd1;
      end
      MONTHS: begin
        days <= days + 22'(days_in_month(m, leap_t));
        m    <= m + 4'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bcd2counter.sv
// Testbench for bcd2counter: directed and random requests, expected results
// queued at issue time and checked by an independent monitor on each done.
module tb_bcd2counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] year_bcd = '0;
  logic [7:0]  month_bcd = '0, day_bcd = '0, hour_bcd = '0, minute_bcd = '0, second_bcd = '0;
  logic        busy, done, err;
  logic [63:0] counter;

  bcd2counter #(.EPOCH_YEAR(1970), .MAX_YEAR(9999), .COUNTER_W(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .year_bcd(year_bcd), .month_bcd(month_bcd), .day_bcd(day_bcd),
    .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
    .busy(busy), .done(done), .err(err), .counter(counter)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              err;
    longint unsigned cnt;
    int              lat;
    int              scyc;
  } exp_t;

  exp_t            q[$];
  exp_t            mon_e;
  int              errors = 0;
  int              checks = 0;
  longint unsigned model_cnt = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // ---------------- reference model (calendar arithmetic) ----------------
  function automatic bit is_leap(input int yr);
    return (yr % 4 == 0) && ((yr % 100 != 0) || (yr % 400 == 0));
  endfunction

  function automatic int mdays(input int mo, input int yr);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo < 1 || mo > 12) return 0;
    return t[mo-1] + ((mo == 2 && is_leap(yr)) ? 1 : 0);
  endfunction

  function automatic int leaps_before(input int yr);
    return (yr - 1) / 4 - (yr - 1) / 100 + (yr - 1) / 400;
  endfunction

  function automatic void model(input logic [15:0] yb, input logic [7:0] mb, input logic [7:0] db,
                                input logic [7:0] hb, input logic [7:0] nb, input logic [7:0] sb,
                                output bit ok, output longint unsigned cnt, output int lat);
    logic [55:0] all;
    int yr, mo, d, h, mi, s, days;
    int cum[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
    bit nib;
    all = {yb, mb, db, hb, nb, sb};
    nib = 1;
    for (int i = 0; i < 14; i++) if (int'(all[i*4 +: 4]) > 9) nib = 0;
    yr = int'(yb[15:12]) * 1000 + int'(yb[11:8]) * 100 + int'(yb[7:4]) * 10 + int'(yb[3:0]);
    mo = int'(mb[7:4]) * 10 + int'(mb[3:0]);
    d  = int'(db[7:4]) * 10 + int'(db[3:0]);
    h  = int'(hb[7:4]) * 10 + int'(hb[3:0]);
    mi = int'(nb[7:4]) * 10 + int'(nb[3:0]);
    s  = int'(sb[7:4]) * 10 + int'(sb[3:0]);
    ok = nib && yr >= 1970 && yr <= 9999 && mo >= 1 && mo <= 12 &&
         d >= 1 && d <= mdays(mo, yr) && h <= 23 && mi <= 59 && s <= 59;
    cnt = 0;
    lat = 2;
    if (ok) begin
      days = 365 * (yr - 1970) + leaps_before(yr) - leaps_before(1970) + cum[mo-1] +
             ((mo > 2 && is_leap(yr)) ? 1 : 0) + d - 1;
      cnt  = longint'(days) * 86400 + longint'(h * 3600 + mi * 60 + s);
      lat  = 3 + (yr - 1970) + (mo - 1);
    end
  endfunction

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] to_bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- monitor: pops an expectation on every done ----------------
  // Latency counts clock edges inclusive of the start edge up to the edge
  // at which done is first seen high.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        mon_e = q.pop_front();
        check("err", longint'(err), longint'(mon_e.err));
        check("counter", counter, mon_e.cnt);
        check("latency", longint'(cyc - mon_e.scyc + 1), longint'(mon_e.lat));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge while the DUT is idle (or showing done).
  task automatic req(input logic [15:0] yb, input logic [7:0] mb, input logic [7:0] db,
                     input logic [7:0] hb, input logic [7:0] nb, input logic [7:0] sb);
    bit ok;
    longint unsigned cnt;
    int lat;
    exp_t e;
    model(yb, mb, db, hb, nb, sb, ok, cnt, lat);
    if (ok) model_cnt = cnt;
    e.err  = !ok;
    e.cnt  = model_cnt;
    e.lat  = lat;
    e.scyc = cyc + 1;
    q.push_back(e);
    year_bcd = yb; month_bcd = mb; day_bcd = db;
    hour_bcd = hb; minute_bcd = nb; second_bcd = sb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    bit busy_bad = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      if (busy !== !seen) busy_bad = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 20000 cycles", tag);
    end
    check({tag, "_busy"}, longint'(busy_bad), 0);
  endtask

  task automatic run(input int yr, input int mo, input int d, input int h, input int mi, input int s,
                     input string tag);
    req(to_bcd4(yr), to_bcd2(mo), to_bcd2(d), to_bcd2(h), to_bcd2(mi), to_bcd2(s));
    wait_done(tag);
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    check("rst_counter", counter, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run(1970, 1, 1, 0, 0, 0, "epoch");
    check("epoch_value", counter, 0);
    run(2000, 3, 1, 0, 0, 0, "y2000");
    check("y2000_value", counter, 64'd951868800);
    run(2024, 8, 30, 16, 14, 50, "y2024");
    check("y2024_value", counter, 64'd1725034490);
    run(2000, 2, 29, 12, 0, 0, "leap2000");
    run(2100, 2, 29, 0, 0, 0, "noleap2100");
    run(2023, 2, 29, 0, 0, 0, "noleap2023");
    req(16'h2020, 8'h13, 8'h01, 8'h00, 8'h00, 8'h00); wait_done("month13");
    req(16'h2020, 8'h01, 8'h01, 8'h00, 8'h00, 8'h1A); wait_done("sec1A");
    run(1969, 12, 31, 23, 59, 59, "y1969");
    run(2023, 4, 31, 0, 0, 0, "apr31");
    run(2023, 1, 0, 0, 0, 0, "day0");
    run(2023, 0, 5, 0, 0, 0, "month0");
    run(2023, 6, 5, 24, 0, 0, "hour24");
    run(2023, 6, 5, 0, 60, 0, "min60");
    req(16'h1A70, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00); wait_done("yearnib");
    run(9999, 12, 31, 23, 59, 59, "maxyear");
    run(1970, 12, 31, 23, 59, 59, "epoch_end");

    // Back-to-back: each request starts in the cycle done is showing
    run(1971, 1, 1, 0, 0, 1, "b2b_a");
    run(1972, 3, 1, 0, 0, 0, "b2b_b");
    run(1970, 1, 1, 0, 0, 0, "b2b_c");

    // Random requests, some deliberately out of range
    for (int n = 0; n < 30; n++) begin
      int yr, mo, d, h, mi, s;
      yr = $urandom_range(1965, 2040);
      mo = ($urandom_range(0, 15) == 0) ? $urandom_range(13, 15) : $urandom_range(1, 12);
      d  = $urandom_range(1, 31);
      h  = ($urandom_range(0, 9) == 0) ? 24 : $urandom_range(0, 23);
      mi = ($urandom_range(0, 9) == 0) ? 60 : $urandom_range(0, 59);
      s  = $urandom_range(0, 59);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run(yr, mo, d, h, mi, s, "rand");
    end

    // Second start while busy plus mid-run input changes: one done, first inputs
    req(to_bcd4(2024), to_bcd2(8), to_bcd2(30), to_bcd2(16), to_bcd2(14), to_bcd2(50));
    repeat (5) @(negedge clk);
    year_bcd = 16'h1999; month_bcd = 8'h05; day_bcd = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hour_bcd = 8'h03; second_bcd = 8'h07;
    wait_done("dbl");
    check("dbl_value", counter, 64'd1725034490);
    repeat (12) @(negedge clk);

    // Reset during YEARS of a 2024 request aborts and clears the counter
    req(to_bcd4(2024), to_bcd2(8), to_bcd2(30), to_bcd2(16), to_bcd2(14), to_bcd2(50));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    q.delete();
    model_cnt = 0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_counter", counter, 0);
    check("abort_done", longint'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);
    run(1970, 1, 2, 0, 0, 0, "post_rst");
    check("post_rst_value", counter, 64'd86400);

    repeat (5) @(negedge clk);
    check("queue_empty", longint'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
